// File: rtl/redux_pkg.sv
// redux_pkg: definitions shared by the redux boot loader and its sub-modules.
//   WORD_W  - program byte / instruction memory data width
//   ADDR_W  - instruction memory address width (256 entries)
//   state_e - loader state encoding
package redux_pkg;

    localparam int WORD_W = 8;
    localparam int ADDR_W = 8;

    // Fixed encodings so the states read the same in waveforms and older tools.
    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RUN     = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

endpackage

// File: rtl/redux_watchdog.sv
// redux_watchdog: clearable cycle counter for the loader's RUN phase.
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   clr    - zero the counter this cycle (takes priority over en)
//   en     - advance the counter by one
//   expire - counter currently holds MAX_CYCLES-1
module redux_watchdog #(
    parameter int MAX_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = (cnt_q == CNT_LAST);

    // Holding at the limit keeps the count from wrapping if en stays high.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/redux_loader.sv
// redux_loader: boot loader in front of the redux core.
// Streams a program into instruction memory from address 0, then releases the
// core reset and watches the PC until it leaves the program (done) or the
// watchdog expires (timeout).
//   clk, reset             - system clock; synchronous active-high reset
//   in_valid/in_ready      - byte stream handshake; in_data byte, in_last marks end
//   imem_we/addr/wdata     - instruction memory write port (registered)
//   cpu_reset              - reset to the core, high except while running
//   cpu_pc                 - core program counter
//   prog_len               - bytes loaded (1..256)
//   done, timeout          - sticky completion flags
module redux_loader
    import redux_pkg::*;
#(
    parameter int MAX_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic [ADDR_W:0]   prog_len,
    output logic              done,
    output logic              timeout
);

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] wr_ptr_q,     wr_ptr_d;
    logic [ADDR_W:0]   prog_len_q,   prog_len_d;
    logic              imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
    logic [WORD_W-1:0] imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q,  cpu_reset_d;
    logic              done_q,       done_d;
    logic              timeout_q,    timeout_d;

    logic hs;
    logic wd_expire;

    // Gated by reset so no byte is taken while the loader is being cleared.
    assign in_ready = (state_q == ST_LOAD) && !reset;
    assign hs       = in_valid && in_ready;

    redux_watchdog #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_q == ST_ARM),
        .en     (state_q == ST_RUN),
        .expire (wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        prog_len_d   = prog_len_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        done_d       = done_q;
        timeout_d    = timeout_q;

        case (state_q)
            ST_LOAD: begin
                if (hs) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = wr_ptr_q;
                    imem_wdata_d = in_data;
                    prog_len_d   = {1'b0, wr_ptr_q} + (ADDR_W + 1)'(1);
                    // A full memory ends the load without wrapping the pointer.
                    if (in_last || (wr_ptr_q == '1)) begin
                        state_d = ST_ARM;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    end
                end
            end
            ST_ARM: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // PC completion is checked first so it wins a tie with the watchdog.
                if ({1'b0, cpu_pc} >= prog_len_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (wd_expire) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // The core runs only while the next state is RUN, so it is still held
        // through the ARM cycle after the final write lands.
        cpu_reset_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            wr_ptr_q     <= '0;
            prog_len_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            prog_len_q   <= prog_len_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign prog_len   = prog_len_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_redux_loader.sv
// tb_redux_loader: bench for redux_loader with a short watchdog (32 cycles).
// Directed table vectors plus randomized loads whose outcome comes from a
// PC-trace reference model.
module tb_redux_loader;

    localparam int MC = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       imem_we;
    logic [7:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_reset;
    logic [7:0] cpu_pc;
    logic [8:0] prog_len;
    logic       done;
    logic       timeout;

    always #5 clk = ~clk;

    redux_loader #(
        .MAX_CYCLES (MC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .cpu_pc     (cpu_pc),
        .prog_len   (prog_len),
        .done       (done),
        .timeout    (timeout)
    );

    // One load-and-run scenario. The PC trace during RUN is: pc(r) = jump_val
    // once r >= jump_at, otherwise r (ramp) or hold_val.
    typedef struct {
        int nbytes;
        bit use_last;
        bit gaps;
        bit rnd_data;
        bit ramp;
        int hold_val;
        int jump_at;
        int jump_val;
        int exp_len;
        bit exp_done;
        int exp_cycles;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=%0h expected=%0h", nm, idx, act, exp);
        end
    endtask

    function automatic int pc_of(input vec_t v, input int r);
        if (r >= v.jump_at) return v.jump_val;
        return v.ramp ? r : v.hold_val;
    endfunction

    // Reference: the run ends on the first RUN cycle whose PC is at or past the
    // program end; failing that, the MC-th RUN cycle ends it as a timeout.
    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        m.exp_len    = (v.nbytes > 256) ? 256 : v.nbytes;
        m.exp_done   = 1'b0;
        m.exp_cycles = MC;
        for (int r = 0; r < MC; r++) begin
            if (pc_of(v, r) >= m.exp_len) begin
                m.exp_done   = 1'b1;
                m.exp_cycles = r + 1;
                break;
            end
        end
        return m;
    endfunction

    task automatic do_reset(input int idx);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
        cpu_pc   = 8'h00;
        @(posedge clk); #1;
        chk("ready_in_reset", idx, in_ready, 0);
        @(posedge clk); #1;
        chk("ready_in_reset2", idx, in_ready, 0);
        chk("rst_cpu_reset", idx, cpu_reset, 1);
        chk("rst_prog_len", idx, prog_len, 0);
        chk("rst_done", idx, done, 0);
        chk("rst_timeout", idx, timeout, 0);
        chk("rst_we", idx, imem_we, 0);
        chk("rst_addr", idx, imem_addr, 0);
        reset = 1'b0;
        #1;
        chk("ready_after_reset", idx, in_ready, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [7:0] data;
        bit         term;
        do_reset(idx);
        for (int i = 0; i < v.nbytes; i++) begin
            if (v.gaps && i > 0) begin
                in_valid = 1'b0;
                in_last  = 1'($urandom);
                in_data  = 8'($urandom);
                @(posedge clk); #1;
                chk("gap_we", idx, imem_we, 0);
            end
            data     = v.rnd_data ? 8'($urandom) : 8'(i);
            in_valid = 1'b1;
            in_data  = data;
            in_last  = v.use_last && (i == v.nbytes - 1);
            chk("load_ready", idx, in_ready, 1);
            @(posedge clk); #1;
            chk("wr_we", idx, imem_we, 1);
            chk("wr_addr", idx, imem_addr, i);
            chk("wr_data", idx, imem_wdata, data);
        end
        // ARM cycle: keep offering bytes, they must be ignored
        in_last = 1'b0;
        in_data = 8'($urandom);
        chk("arm_ready", idx, in_ready, 0);
        chk("arm_cpu_reset", idx, cpu_reset, 1);
        chk("prog_len", idx, prog_len, v.exp_len);
        @(posedge clk); #1;
        chk("arm_we", idx, imem_we, 0);
        chk("run_entry_cpu_reset", idx, cpu_reset, 0);
        term = 1'b0;
        for (int r = 0; r < MC + 4 && !term; r++) begin
            cpu_pc = 8'(pc_of(v, r));
            @(posedge clk); #1;
            chk("run_we", idx, imem_we, 0);
            if (r == v.exp_cycles - 1) begin
                chk("end_done", idx, done, v.exp_done);
                chk("end_timeout", idx, timeout, !v.exp_done);
                chk("end_cpu_reset", idx, cpu_reset, 1);
                term = 1'b1;
            end else begin
                chk("run_cpu_reset", idx, cpu_reset, 0);
                chk("run_done", idx, done, 0);
                chk("run_timeout", idx, timeout, 0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            cpu_pc   = 8'($urandom);
            @(posedge clk); #1;
            chk("sticky_done", idx, done, v.exp_done);
            chk("sticky_timeout", idx, timeout, !v.exp_done);
            chk("sticky_cpu_reset", idx, cpu_reset, 1);
            chk("sticky_ready", idx, in_ready, 0);
            chk("sticky_we", idx, imem_we, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic mid_run_reset(input int idx);
        do_reset(idx);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'hA0 + i);
            in_last  = (i == 7);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk); #1;
        chk("mr_running", idx, cpu_reset, 0);
        for (int r = 0; r < 5; r++) begin
            cpu_pc = 8'h00;
            @(posedge clk); #1;
        end
        chk("mr_still_running", idx, cpu_reset, 0);
        reset = 1'b1;
        #1;
        chk("mr_ready_in_reset", idx, in_ready, 0);
        @(posedge clk); #1;
        chk("mr_cpu_reset", idx, cpu_reset, 1);
        chk("mr_prog_len", idx, prog_len, 0);
        chk("mr_done", idx, done, 0);
        chk("mr_timeout", idx, timeout, 0);
        chk("mr_we", idx, imem_we, 0);
        reset = 1'b0;
        #1;
        chk("mr_ready_after", idx, in_ready, 1);
        // write pointer restarts at address 0
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_last  = 1'b0;
        @(posedge clk); #1;
        chk("mr_first_we", idx, imem_we, 1);
        chk("mr_first_addr", idx, imem_addr, 0);
        chk("mr_first_data", idx, imem_wdata, 8'h5A);
        chk("mr_first_len", idx, prog_len, 1);
        in_valid = 1'b0;
    endtask

    vec_t tbl[6];

    initial begin
        vec_t v;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        cpu_pc   = 8'h00;

        tbl[0] = '{nbytes:16,  use_last:1, gaps:0, rnd_data:0, ramp:1, hold_val:0, jump_at:1000, jump_val:0,
                   exp_len:16,  exp_done:1, exp_cycles:17};
        tbl[1] = '{nbytes:16,  use_last:1, gaps:1, rnd_data:0, ramp:1, hold_val:0, jump_at:1000, jump_val:0,
                   exp_len:16,  exp_done:1, exp_cycles:17};
        tbl[2] = '{nbytes:16,  use_last:1, gaps:0, rnd_data:0, ramp:0, hold_val:3, jump_at:1000, jump_val:0,
                   exp_len:16,  exp_done:0, exp_cycles:32};
        tbl[3] = '{nbytes:256, use_last:0, gaps:0, rnd_data:0, ramp:1, hold_val:0, jump_at:1000, jump_val:0,
                   exp_len:256, exp_done:0, exp_cycles:32};
        tbl[4] = '{nbytes:1,   use_last:1, gaps:0, rnd_data:1, ramp:0, hold_val:0, jump_at:5,    jump_val:1,
                   exp_len:1,   exp_done:1, exp_cycles:6};
        // PC reaches the end on the same cycle the watchdog expires
        tbl[5] = '{nbytes:20,  use_last:1, gaps:1, rnd_data:1, ramp:0, hold_val:5, jump_at:31,   jump_val:20,
                   exp_len:20,  exp_done:1, exp_cycles:32};

        for (int t = 0; t < 6; t++) begin
            run_vec(tbl[t], t);
        end

        mid_run_reset(100);

        for (int t = 0; t < 8; t++) begin
            v.nbytes   = int'($urandom_range(1, 40));
            v.use_last = 1'b1;
            v.gaps     = 1'($urandom);
            v.rnd_data = 1'b1;
            v.ramp     = 1'($urandom);
            v.hold_val = int'($urandom_range(0, 45));
            v.jump_at  = int'($urandom_range(0, 40));
            v.jump_val = int'($urandom_range(0, 60));
            v = model(v);
            run_vec(v, 200 + t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "time limit");
    end

endmodule
